// File: rtl/tap_saver.sv
// tap_saver: streams a RAM region out as an ORIC TAP image. The image is
// sync bytes, a 9-byte header, a zero-terminated name (up to 15 characters)
// and the data bytes, sent over a valid/ready byte stream.
module tap_saver (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic        prog_asm,
   input  logic        autorun,
   input  logic [15:0] start_addr,
   input  logic [15:0] end_addr,
   input  logic [15:0] name_addr,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_data,
   input  logic        mem_ready,
   output logic [7:0]  tap_data,
   output logic        tap_valid,
   input  logic        tap_ready,
   output logic        tap_last,
   output logic [24:0] tap_offset,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_HDR, S_NAME_RD, S_NAME_WAIT, S_NAME_OUT, S_NAME_TERM,
      S_DATA_RD, S_DATA_WAIT, S_DATA_OUT, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;        // sync / header / name index
   logic [16:0] addr_q, addr_d;      // 17 bits so end_addr=$FFFF cannot wrap
   logic [15:0] start_q, start_d;
   logic [15:0] end_q, end_d;
   logic [15:0] name_q, name_d;
   logic        asm_q, asm_d;
   logic        auto_q, auto_d;
   logic [7:0]  byte_q, byte_d;      // last captured RAM byte
   logic [24:0] offset_q, offset_d;
   logic        err_q, err_d;
   logic        hs;

   assign hs         = tap_valid & tap_ready;
   assign tap_offset = offset_q;
   assign err        = err_q;

   // Outputs decoded from the current state; stable while a byte is stalled.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      tap_valid = 1'b0;
      tap_data  = 8'h00;
      tap_last  = 1'b0;
      mem_rd    = 1'b0;
      mem_addr  = 16'h0000;
      busy      = (state_q != S_IDLE) && (state_q != S_DONE);
      done      = (state_q == S_DONE);
      case (state_q)
         S_SYNC: begin
            tap_valid = 1'b1;
            tap_data  = (cnt_q == 4'd3) ? 8'h24 : 8'h16;
         end
         S_HDR: begin
            tap_valid = 1'b1;
            case (cnt_q)
               4'd2:    tap_data = asm_q ? 8'h80 : 8'h00;
               4'd3:    tap_data = !auto_q ? 8'h00 : (asm_q ? 8'h80 : 8'hC7);
               4'd4:    tap_data = end_q[15:8];
               4'd5:    tap_data = end_q[7:0];
               4'd6:    tap_data = start_q[15:8];
               4'd7:    tap_data = start_q[7:0];
               default: tap_data = 8'h00;
            endcase
         end
         S_NAME_RD: begin
            mem_rd   = 1'b1;
            mem_addr = name_q + {12'd0, cnt_q};
         end
         S_NAME_WAIT: mem_addr = name_q + {12'd0, cnt_q};
         S_NAME_OUT: begin
            tap_valid = 1'b1;
            tap_data  = byte_q;
         end
         S_NAME_TERM: tap_valid = 1'b1;
         S_DATA_RD: begin
            mem_rd   = 1'b1;
            mem_addr = addr_q[15:0];
         end
         S_DATA_WAIT: mem_addr = addr_q[15:0];
         S_DATA_OUT: begin
            tap_valid = 1'b1;
            tap_data  = byte_q;
            tap_last  = (addr_q == {1'b0, end_q});
         end
         default: ;
      endcase
   end

   // Next-state logic: parameter latching, sequencing and RAM read handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      start_d  = start_q;
      end_d    = end_q;
      name_d   = name_q;
      asm_d    = asm_q;
      auto_d   = auto_q;
      byte_d   = byte_q;
      offset_d = hs ? offset_q + 25'd1 : offset_q;
      err_d    = 1'b0;
      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (start) begin
               if (start_addr > end_addr) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = S_SYNC;
                  cnt_d    = 4'd0;
                  offset_d = 25'd0;
                  addr_d   = {1'b0, start_addr};
                  start_d  = start_addr;
                  end_d    = end_addr;
                  name_d   = name_addr;
                  asm_d    = prog_asm;
                  auto_d   = autorun;
               end
            end
            S_SYNC: if (hs) begin
               if (cnt_q == 4'd3) begin
                  state_d = S_HDR;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_HDR: if (hs) begin
               if (cnt_q == 4'd8) begin
                  state_d = S_NAME_RD;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
            S_NAME_RD: state_d = S_NAME_WAIT;
            S_NAME_WAIT: if (mem_ready) begin
               if (mem_data == 8'h00) begin
                  state_d = S_NAME_TERM;
               end else begin
                  byte_d  = mem_data;
                  state_d = S_NAME_OUT;
               end
            end
            // The 15th character closes the name without another read.
            S_NAME_OUT: if (hs) begin
               if (cnt_q == 4'd14) begin
                  state_d = S_NAME_TERM;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
                  state_d = S_NAME_RD;
               end
            end
            S_NAME_TERM: if (hs) state_d = S_DATA_RD;
            S_DATA_RD:   state_d = S_DATA_WAIT;
            S_DATA_WAIT: if (mem_ready) begin
               byte_d  = mem_data;
               state_d = S_DATA_OUT;
            end
            S_DATA_OUT: if (hs) begin
               if (addr_q == {1'b0, end_q}) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + 17'd1;
                  state_d = S_DATA_RD;
               end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 17'd0;
         start_q  <= 16'h0000;
         end_q    <= 16'h0000;
         name_q   <= 16'h0000;
         asm_q    <= 1'b0;
         auto_q   <= 1'b0;
         byte_q   <= 8'h00;
         offset_q <= 25'd0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         start_q  <= start_d;
         end_q    <= end_d;
         name_q   <= name_d;
         asm_q    <= asm_d;
         auto_q   <= auto_d;
         byte_q   <= byte_d;
         offset_q <= offset_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_tap_saver.sv
// Directed testbench for tap_saver: RAM responder with configurable latency,
// stream consumer with optional backpressure, and a negedge monitor.
module tb_tap_saver;

   typedef logic [7:0] bq_t[$];

   logic        clk_sys = 1'b0;
   logic        reset_n, start, abort, prog_asm, autorun;
   logic [15:0] start_addr, end_addr, name_addr;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_data;
   logic        mem_ready;
   logic [7:0]  tap_data;
   logic        tap_valid, tap_ready, tap_last;
   logic [24:0] tap_offset;
   logic        busy, done, err;

   logic [7:0]  mem [0:65535];

   int n_checks = 0, n_pass = 0, n_fail = 0;

   // monitor state
   logic [7:0]  q_data[$];
   logic        q_last[$];
   logic [24:0] q_off[$];
   int cyc = 0, start_cyc = 0, done_cyc = 0, last_hs_cyc = 0;
   int done_cnt = 0, err_cnt = 0, valid_cnt = 0, busy_cnt = 0, stab_err = 0;
   logic busy_at_done = 1'b0;

   // responder state
   bit rnd_ready = 1'b0, rnd_lat = 1'b0;
   int rd_cnt = 0, rd_overlap = 0, hit_400f = 0;

   tap_saver dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .start(start), .abort(abort),
      .prog_asm(prog_asm), .autorun(autorun), .start_addr(start_addr),
      .end_addr(end_addr), .name_addr(name_addr), .mem_addr(mem_addr),
      .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .tap_data(tap_data), .tap_valid(tap_valid), .tap_ready(tap_ready),
      .tap_last(tap_last), .tap_offset(tap_offset), .busy(busy),
      .done(done), .err(err)
   );

   initial forever #5 clk_sys = ~clk_sys;

   // RAM responder and consumer: drive just after each rising edge.
   initial begin
      bit          pend;
      int          wcnt;
      logic [15:0] paddr;
      pend = 1'b0; wcnt = 0; paddr = 16'h0;
      mem_ready = 1'b0; mem_data = 8'h00; tap_ready = 1'b1;
      forever begin
         @(posedge clk_sys); #1;
         tap_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         mem_ready = 1'b0;
         mem_data  = 8'($urandom);
         if (!reset_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               if (wcnt <= 1) begin
                  mem_ready = 1'b1;
                  mem_data  = mem[paddr];
                  pend      = 1'b0;
               end else begin
                  wcnt--;
               end
            end
            if (mem_rd) begin
               rd_cnt++;
               if (pend) rd_overlap++;
               if (mem_addr == 16'h400F) hit_400f++;
               pend  = 1'b1;
               paddr = mem_addr;
               wcnt  = rnd_lat ? $urandom_range(1, 7) : 1;
            end
         end
      end
   end

   // Monitor on the falling edge: handshakes, stall stability, pulses.
   initial begin
      bit          stall_prev;
      logic [7:0]  pd;
      logic        pl;
      logic [24:0] po;
      stall_prev = 1'b0; pd = 8'h0; pl = 1'b0; po = 25'd0;
      forever begin
         @(negedge clk_sys);
         if (start) start_cyc = cyc;
         if (tap_valid && tap_ready) begin
            q_data.push_back(tap_data);
            q_last.push_back(tap_last);
            q_off.push_back(tap_offset);
            if (tap_last) last_hs_cyc = cyc;
         end
         if (stall_prev && reset_n)
            if (tap_valid !== 1'b1 || tap_data !== pd || tap_last !== pl || tap_offset !== po)
               stab_err++;
         stall_prev = reset_n && !abort && tap_valid && !tap_ready;
         pd = tap_data; pl = tap_last; po = tap_offset;
         if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
         end
         if (err) err_cnt++;
         if (tap_valid) valid_cnt++;
         if (busy) busy_cnt++;
         cyc++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic ps, input logic ar, input logic [15:0] sa,
                           input logic [15:0] ea, input logic [15:0] na);
      @(posedge clk_sys); #1;
      prog_asm = ps; autorun = ar; start_addr = sa; end_addr = ea; name_addr = na;
      start = 1'b1;
      @(posedge clk_sys); #1;
      start = 1'b0;
      // Scramble the parameters: the block must use the latched copies.
      prog_asm = ~ps; autorun = ~ar;
      start_addr = 16'($urandom); end_addr = 16'($urandom); name_addr = 16'($urandom);
   endtask

   task automatic wait_done(input string tag, input int d0);
      for (int i = 0; i < 4000 && done_cnt == d0; i++) begin
         @(negedge clk_sys); #1;
      end
      repeat (3) @(negedge clk_sys);
      #1;
      check({tag, " done pulses"}, done_cnt - d0, 1);
      check({tag, " done after last"}, done_cyc - last_hs_cyc, 1);
      check({tag, " busy low at done"}, busy_at_done, 1'b0);
   endtask

   task automatic wait_bytes(input string tag, input int target);
      for (int i = 0; i < 4000 && q_data.size() < target; i++) begin
         @(negedge clk_sys); #1;
      end
      check({tag, " progress reached"}, q_data.size() >= target, 1'b1);
   endtask

   task automatic check_stream(input string tag, input int base, input bq_t exp);
      int n;
      int bad_d = -1, bad_l = -1, bad_o = -1;
      n = q_data.size() - base;
      check({tag, " length"}, n, exp.size());
      for (int i = 0; i < n && i < exp.size(); i++) begin
         if (bad_d < 0 && q_data[base+i] !== exp[i]) bad_d = i;
         if (bad_l < 0 && q_last[base+i] !== (i == exp.size() - 1)) bad_l = i;
         if (bad_o < 0 && q_off[base+i] !== 25'(i)) bad_o = i;
      end
      check({tag, " first bad data idx"}, bad_d, -1);
      check({tag, " first bad last idx"}, bad_l, -1);
      check({tag, " first bad offset idx"}, bad_o, -1);
   endtask

   // Reference image built from the format description and the RAM contents.
   function automatic bq_t model(input logic ps, input logic ar, input logic [15:0] sa,
                                 input logic [15:0] ea, input logic [15:0] na);
      bq_t e;
      int  k;
      e = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00};
      e.push_back(ps ? 8'h80 : 8'h00);
      e.push_back(!ar ? 8'h00 : (ps ? 8'h80 : 8'hC7));
      e.push_back(ea[15:8]); e.push_back(ea[7:0]);
      e.push_back(sa[15:8]); e.push_back(sa[7:0]);
      e.push_back(8'h00);
      k = 0;
      while (k < 15 && mem[16'(na + k)] != 8'h00) begin
         e.push_back(mem[16'(na + k)]);
         k++;
      end
      e.push_back(8'h00);
      for (int a = int'(sa); a <= int'(ea); a++) e.push_back(mem[16'(a)]);
      return e;
   endfunction

   initial begin
      bq_t exp1, exp2, exp5, e;
      int  base, d0, r0, h0, e0, v0, b0;
      reset_n = 1'b1; start = 1'b0; abort = 1'b0; prog_asm = 1'b0; autorun = 1'b0;
      start_addr = 16'h0; end_addr = 16'h0; name_addr = 16'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      #2 reset_n = 1'b0;

      // Reset state
      repeat (3) @(negedge clk_sys);
      check("reset ctrl outputs", {tap_valid, tap_last, busy, done, err, mem_rd}, 6'b0);
      check("reset tap_offset", tap_offset, 25'd0);
      check("reset mem_addr", mem_addr, 16'h0000);
      check("reset tap_data", tap_data, 8'h00);
      reset_n = 1'b1;

      // T1: BASIC, autorun, name "AB", data 11 22 33
      mem[16'h0300] = 8'h41; mem[16'h0301] = 8'h42; mem[16'h0302] = 8'h00;
      mem[16'h0501] = 8'h11; mem[16'h0502] = 8'h22; mem[16'h0503] = 8'h33;
      exp1 = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h00, 8'hC7, 8'h05, 8'h03,
               8'h05, 8'h01, 8'h00, 8'h41, 8'h42, 8'h00, 8'h11, 8'h22, 8'h33};
      base = q_data.size(); d0 = done_cnt; r0 = rd_cnt;
      do_start(1'b0, 1'b1, 16'h0501, 16'h0503, 16'h0300);
      @(negedge clk_sys); #1;
      check("t1 cycle1 busy", busy, 1'b1);
      check("t1 cycle1 valid", tap_valid, 1'b1);
      check("t1 cycle1 data", tap_data, 8'h16);
      wait_done("t1", d0);
      check_stream("t1", base, exp1);
      check("t1 start-to-done cycles", done_cyc - start_cyc, 32);
      check("t1 read count", rd_cnt - r0, 6);

      // T2: machine code, autorun, empty name, single data byte
      mem[16'h0700] = 8'h00; mem[16'hA000] = 8'h5A;
      exp2 = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h80, 8'hA0, 8'h00,
               8'hA0, 8'h00, 8'h00, 8'h00, 8'h5A};
      base = q_data.size(); d0 = done_cnt; r0 = rd_cnt;
      do_start(1'b1, 1'b1, 16'hA000, 16'hA000, 16'h0700);
      wait_done("t2", d0);
      check_stream("t2", base, exp2);
      check("t2 read count", rd_cnt - r0, 2);

      // T3: random backpressure and random RAM latency
      mem[16'h0800] = 8'h48; mem[16'h0801] = 8'h45; mem[16'h0802] = 8'h4C;
      mem[16'h0803] = 8'h4C; mem[16'h0804] = 8'h4F; mem[16'h0805] = 8'h00;
      for (int i = 0; i < 8; i++) mem[16'h2000 + i] = 8'(8'h90 + i);
      e = model(1'b0, 1'b0, 16'h2000, 16'h2007, 16'h0800);
      rnd_ready = 1'b1; rnd_lat = 1'b1;
      base = q_data.size(); d0 = done_cnt; r0 = rd_cnt;
      do_start(1'b0, 1'b0, 16'h2000, 16'h2007, 16'h0800);
      wait_done("t3", d0);
      check_stream("t3", base, e);
      check("t3 read count", rd_cnt - r0, 14);
      check("t3 stall stability errors", stab_err, 0);
      check("t3 overlapping reads", rd_overlap, 0);
      rnd_ready = 1'b0; rnd_lat = 1'b0;

      // T4: 20-character name truncated to 15
      for (int i = 0; i < 20; i++) mem[16'h4000 + i] = 8'(8'h41 + i);
      mem[16'h4100] = 8'h77;
      e = model(1'b1, 1'b0, 16'h4100, 16'h4100, 16'h4000);
      base = q_data.size(); d0 = done_cnt; r0 = rd_cnt; h0 = hit_400f;
      do_start(1'b1, 1'b0, 16'h4100, 16'h4100, 16'h4000);
      wait_done("t4", d0);
      check_stream("t4", base, e);
      check("t4 15th name char", q_data[base+27], 8'h4F);
      check("t4 name terminator", q_data[base+28], 8'h00);
      check("t4 read count", rd_cnt - r0, 16);
      check("t4 read of name+15", hit_400f - h0, 0);

      // T5: data at the top of memory
      mem[16'h0010] = 8'h00; mem[16'hFFFE] = 8'hEE; mem[16'hFFFF] = 8'hFF;
      exp5 = '{8'h16, 8'h16, 8'h16, 8'h24, 8'h00, 8'h00, 8'h80, 8'h00, 8'hFF, 8'hFF,
               8'hFF, 8'hFE, 8'h00, 8'h00, 8'hEE, 8'hFF};
      base = q_data.size(); d0 = done_cnt;
      do_start(1'b1, 1'b0, 16'hFFFE, 16'hFFFF, 16'h0010);
      wait_done("t5", d0);
      check_stream("t5", base, exp5);

      // T6: start > end gives err only
      d0 = done_cnt; e0 = err_cnt; v0 = valid_cnt; b0 = busy_cnt;
      do_start(1'b0, 1'b0, 16'h0600, 16'h05FF, 16'h0010);
      @(negedge clk_sys); #1;
      check("t6 cycle1 err", err, 1'b1);
      check("t6 cycle1 busy", busy, 1'b0);
      check("t6 cycle1 valid", tap_valid, 1'b0);
      repeat (6) @(negedge clk_sys);
      #1;
      check("t6 err pulses", err_cnt - e0, 1);
      check("t6 valid cycles", valid_cnt - v0, 0);
      check("t6 busy cycles", busy_cnt - b0, 0);
      check("t6 done pulses", done_cnt - d0, 0);

      // T7: reset in the data phase, then a clean restart
      base = q_data.size(); d0 = done_cnt;
      do_start(1'b0, 1'b1, 16'h0501, 16'h0503, 16'h0300);
      wait_bytes("t7", base + 17);
      reset_n = 1'b0;
      #1;
      check("t7 rst ctrl outputs", {tap_valid, tap_last, busy, done, err, mem_rd}, 6'b0);
      check("t7 rst tap_offset", tap_offset, 25'd0);
      check("t7 rst mem_addr", mem_addr, 16'h0000);
      check("t7 rst tap_data", tap_data, 8'h00);
      @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (10) @(negedge clk_sys);
      #1;
      check("t7 no done after reset", done_cnt - d0, 0);
      base = q_data.size(); d0 = done_cnt;
      do_start(1'b0, 1'b1, 16'h0501, 16'h0503, 16'h0300);
      wait_done("t7 restart", d0);
      check_stream("t7 restart", base, exp1);

      // T8: abort in the name phase, then a clean restart
      base = q_data.size(); d0 = done_cnt; e0 = err_cnt;
      do_start(1'b1, 1'b0, 16'h4100, 16'h4100, 16'h4000);
      wait_bytes("t8", base + 18);
      @(posedge clk_sys); #1;
      abort = 1'b1;
      @(posedge clk_sys); #1;
      abort = 1'b0;
      @(negedge clk_sys); #1;
      check("t8 valid after abort", tap_valid, 1'b0);
      check("t8 busy after abort", busy, 1'b0);
      repeat (20) @(negedge clk_sys);
      #1;
      check("t8 no done after abort", done_cnt - d0, 0);
      check("t8 no err after abort", err_cnt - e0, 0);
      base = q_data.size(); d0 = done_cnt;
      do_start(1'b1, 1'b1, 16'hA000, 16'hA000, 16'h0700);
      wait_done("t8 restart", d0);
      check_stream("t8 restart", base, exp2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
